// File: rtl/fir_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// fir_frame_ctrl_if
// Control, sample-stream and result-stream bundle for fir_frame_ctrl.
//   cfg_we/cfg_addr/cfg_data/cfg_err : coefficient bank write port
//   start/frame_len/busy/done        : frame control and status
//   underrun                         : sticky "source was empty during RUN"
//   s_valid/s_data/s_ready           : sample source (valid/ready)
//   m_valid/m_data/m_last            : FIR result stream (no back-pressure)
// The master modport is the system side; the slave modport is the controller.
// ----------------------------------------------------------------------------
interface fir_frame_ctrl_if #(
  parameter int LEN_W = 8
) ();
  logic                    cfg_we;
  logic [1:0]              cfg_addr;
  logic [7:0]              cfg_data;
  logic                    cfg_err;
  logic                    start;
  logic [LEN_W-1:0]        frame_len;
  logic                    busy;
  logic                    done;
  logic                    underrun;
  logic                    s_valid;
  logic signed [7:0]       s_data;
  logic                    s_ready;
  logic                    m_valid;
  logic signed [10:0]      m_data;
  logic                    m_last;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, frame_len, s_valid, s_data,
    input  cfg_err, busy, done, underrun, s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, frame_len, s_valid, s_data,
    output cfg_err, busy, done, underrun, s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fir_frame_ctrl
// Frame sequencer for a 4-tap FIR shift-register datapath. Holds the
// coefficient bank, primes the FIR history with zeros, streams frame_len
// samples from a valid/ready source, flushes the tail with zeros and tags
// every FIR result with m_valid/m_last.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : control / sample / result bundle (slave side)
//   fir_xn     : sample presented to the FIR
//   fir_w0..3  : coefficient bank presented to the FIR
//   fir_out    : FIR result, FIR_LAT cycles after fir_xn
// ----------------------------------------------------------------------------
module fir_frame_ctrl #(
  parameter int TAPS    = 4,
  parameter int FIR_LAT = 1,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  fir_frame_ctrl_if.slave    bus,
  output logic signed [7:0]  fir_xn,
  output logic [7:0]         fir_w0,
  output logic [7:0]         fir_w1,
  output logic [7:0]         fir_w2,
  output logic [7:0]         fir_w3,
  input  logic signed [10:0] fir_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRIME = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic [LEN_W-1:0] CNT_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
  // Prime and flush each last TAPS-1 cycles; the counter stops at TAPS-2.
  localparam logic [LEN_W-1:0] SIDE_LAST = LEN_W'(TAPS - 2);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_next;
  logic [LEN_W-1:0]   len;
  logic               start_ok;
  logic               slot_tag;
  logic               slot_last;
  logic signed [7:0]  xn_next;
  // Index 0 is aligned with fir_xn; index FIR_LAT is aligned with fir_out.
  logic [FIR_LAT:0]   tag_pipe;
  logic [FIR_LAT:0]   last_pipe;
  logic [7:0]         coef [0:3];

  assign start_ok = (state == IDLE) && bus.start && (bus.frame_len != CNT_ZERO);

  // The source is only ever consumed in RUN, one sample per cycle.
  assign bus.s_ready = (state == RUN);

  assign fir_w0 = coef[0];
  assign fir_w1 = coef[1];
  assign fir_w2 = coef[2];
  assign fir_w3 = coef[3];

  // Next-state, slot counter and the sample/tag loaded into the FIR this cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    xn_next    = 8'sd0;
    slot_tag   = 1'b0;
    slot_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = PRIME;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = IDLE;
        end
      end
      PRIME: begin
        if (cnt == SIDE_LAST) begin
          state_next = RUN;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RUN: begin
        slot_tag = 1'b1;
        // A missing sample still occupies its slot, as a zero.
        if (bus.s_valid) begin
          xn_next = bus.s_data;
        end else begin
          xn_next = 8'sd0;
        end
        if (cnt == (len - CNT_ONE)) begin
          state_next = FLUSH;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      FLUSH: begin
        slot_tag = 1'b1;
        if (cnt == SIDE_LAST) begin
          slot_last  = 1'b1;
          state_next = DRAIN;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      DRAIN: begin
        // m_last/done are high this cycle: the frame is fully delivered.
        if (bus.m_last) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state, sample register, frame length, busy and underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= CNT_ZERO;
      len          <= CNT_ZERO;
      fir_xn       <= 8'sd0;
      bus.busy     <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      fir_xn   <= xn_next;
      bus.busy <= (state_next != IDLE);
      if (start_ok) begin
        len <= bus.frame_len;
      end else begin
        len <= len;
      end
      if (start_ok) begin
        bus.underrun <= 1'b0;
      end else if ((state == RUN) && !bus.s_valid) begin
        bus.underrun <= 1'b1;
      end else begin
        bus.underrun <= bus.underrun;
      end
    end
  end

  // Tag/last delay line that tracks each slot through the FIR latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      tag_pipe[0]  <= slot_tag;
      last_pipe[0] <= slot_last;
      for (int i = 1; i <= FIR_LAT; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // Result stream: capture fir_out when its tag arrives, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_data  <= 11'sd0;
      bus.done    <= 1'b0;
    end else begin
      bus.m_valid <= tag_pipe[FIR_LAT];
      bus.m_last  <= last_pipe[FIR_LAT];
      bus.done    <= last_pipe[FIR_LAT] && (state == DRAIN);
      if (tag_pipe[FIR_LAT]) begin
        bus.m_data <= fir_out;
      end else begin
        bus.m_data <= bus.m_data;
      end
    end
  end

  // Coefficient bank: writable only while idle; other writes flag cfg_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        coef[i] <= 8'd0;
      end
      bus.cfg_err <= 1'b0;
    end else begin
      if (bus.cfg_we && (state == IDLE)) begin
        coef[bus.cfg_addr] <= bus.cfg_data;
      end else begin
        coef[bus.cfg_addr] <= coef[bus.cfg_addr];
      end
      bus.cfg_err <= bus.cfg_we && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fir_frame_ctrl
// Self-checking bench: a behavioural 4-tap FIR sits on the fir_* ports, and a
// scoreboard queue holds the convolution results expected for each frame.
// ----------------------------------------------------------------------------
module tb_fir_frame_ctrl;

  logic clk;
  logic rst;
  logic signed [7:0]  fir_xn;
  logic [7:0]         fir_w0, fir_w1, fir_w2, fir_w3;
  logic signed [10:0] fir_out;
  logic signed [7:0]  x1, x2, x3;

  fir_frame_ctrl_if #(.LEN_W(8)) bus ();

  fir_frame_ctrl #(.TAPS(4), .FIR_LAT(1), .LEN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fir_xn  (fir_xn),
    .fir_w0  (fir_w0),
    .fir_w1  (fir_w1),
    .fir_w2  (fir_w2),
    .fir_w3  (fir_w3),
    .fir_out (fir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural fir_shiftreg: one cycle from fir_xn to fir_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1 <= 8'sd0;
      x2 <= 8'sd0;
      x3 <= 8'sd0;
      fir_out <= 11'sd0;
    end else begin
      fir_out <= 11'($signed(fir_w0) * fir_xn + $signed(fir_w1) * x1 +
                     $signed(fir_w2) * x2 + $signed(fir_w3) * x3);
      x1 <= fir_xn;
      x2 <= x1;
      x3 <= x2;
    end
  end

  typedef struct {
    logic signed [10:0] data;
    logic               last;
  } exp_t;

  exp_t exp_q [$];
  int   errors;
  int   checks;
  int   out_cnt;
  bit   seen_done;
  int   w_model [4];
  int   smp [16];
  logic [15:0] vmask;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Compare whatever the DUT emitted on this edge against the scoreboard.
  task automatic monitor_out();
    exp_t e;
    if (bus.m_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", bus.m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("m_data", bus.m_data, e.data);
        check("m_last", bus.m_last, e.last);
        check("done_with_last", bus.done, e.last);
        if (bus.done) seen_done = 1'b1;
      end
    end else if (bus.done) begin
      check("done_stray", bus.done, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor_out();
  endtask

  task automatic write_coef(input int a, input int v);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a[1:0];
    bus.cfg_data = v[7:0];
    tick();
    bus.cfg_we = 1'b0;
    w_model[a] = v;
    check("cfg_err_idle", bus.cfg_err, 0);
  endtask

  task automatic check_coefs();
    check("coef_w0", fir_w0, w_model[0]);
    check("coef_w1", fir_w1, w_model[1]);
    check("coef_w2", fir_w2, w_model[2]);
    check("coef_w3", fir_w3, w_model[3]);
  endtask

  // Run one frame of smp[0..len-1]; vmask bit i low means slot i is empty.
  // poke: during the first slot also try a coefficient write and a restart.
  task automatic run_frame(input int len, input bit poke);
    exp_t e;
    int acc;
    int fed;
    int guard;
    int xv;
    out_cnt   = 0;
    seen_done = 1'b0;
    for (int n = 0; n < len + 3; n++) begin
      acc = 0;
      for (int j = 0; j < 4; j++) begin
        if ((n - j) >= 0 && (n - j) < len) begin
          xv  = vmask[n-j] ? smp[n-j] : 0;
          acc = acc + w_model[j] * xv;
        end
      end
      e.data = 11'(acc);
      e.last = (n == len + 2);
      exp_q.push_back(e);
    end

    bus.start     = 1'b1;
    bus.frame_len = len[7:0];
    tick();
    bus.start     = 1'b0;
    bus.frame_len = 8'd0;
    check("busy_start", bus.busy, 1);
    check("underrun_clr", bus.underrun, 0);

    fed   = 0;
    guard = 0;
    while (fed < len && guard < 64) begin
      if (bus.s_ready) begin
        bus.s_valid = vmask[fed];
        bus.s_data  = smp[fed][7:0];
        if (poke && fed == 0) begin
          bus.cfg_we    = 1'b1;
          bus.cfg_addr  = 2'd0;
          bus.cfg_data  = 8'h7F;
          bus.start     = 1'b1;
          bus.frame_len = 8'd1;
        end
        fed++;
      end else begin
        bus.s_valid = 1'b0;
      end
      tick();
      guard++;
      if (bus.cfg_we) begin
        bus.cfg_we    = 1'b0;
        bus.start     = 1'b0;
        bus.frame_len = 8'd0;
        check("cfg_err_pulse", bus.cfg_err, 1);
        check("w0_kept", fir_w0, w_model[0]);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'sd0;
    check("slots_fed", fed, len);

    guard = 0;
    while (!seen_done && guard < 64) begin
      tick();
      guard++;
    end
    check("done_seen", seen_done, 1);
    check("out_count", out_cnt, len + 3);
    check("queue_empty", exp_q.size(), 0);
    tick();
    check("idle_after_done", bus.busy, 0);
    check("cfg_err_clear", bus.cfg_err, 0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    out_cnt       = 0;
    seen_done     = 1'b0;
    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_data  = 8'd0;
    bus.start     = 1'b0;
    bus.frame_len = 8'd0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'sd0;
    for (int i = 0; i < 4; i++) w_model[i] = 0;
    for (int i = 0; i < 16; i++) smp[i] = 0;
    vmask = 16'hFFFF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_fir_xn", fir_xn, 0);
    check_coefs();
    rst = 1'b0;
    tick();

    // Ramp frame with unit weights: 1,3,6,10,9,7,4.
    for (int i = 0; i < 4; i++) write_coef(i, 1);
    check_coefs();
    smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 4;
    run_frame(4, 1'b0);

    // Back-to-back frames; the second must carry no history from the first.
    for (int i = 0; i < 4; i++) smp[i] = 4;
    run_frame(4, 1'b0);
    smp[0] = 5;
    run_frame(1, 1'b0);
    check("no_underrun", bus.underrun, 0);

    // Underrun on slot 1: 1,1,4,8,7,7,4, and underrun sticks.
    smp[0] = 1; smp[1] = 9; smp[2] = 3; smp[3] = 4;
    vmask = 16'hFFFD;
    run_frame(4, 1'b0);
    check("underrun_set", bus.underrun, 1);
    tick();
    check("underrun_sticky", bus.underrun, 1);
    vmask = 16'hFFFF;

    // Ignored start with frame_len=0.
    bus.start     = 1'b1;
    bus.frame_len = 8'd0;
    tick();
    bus.start = 1'b0;
    check("len0_busy", bus.busy, 0);
    check("len0_s_ready", bus.s_ready, 0);
    tick();
    check("len0_busy_later", bus.busy, 0);

    // Config guard and restart attempt during RUN: 1,3,2,0,0.
    write_coef(0, 1);
    write_coef(1, 2);
    write_coef(2, 0);
    write_coef(3, 0);
    smp[0] = 1; smp[1] = 1;
    run_frame(2, 1'b1);
    check_coefs();

    // Reset in the middle of RUN.
    bus.start     = 1'b1;
    bus.frame_len = 8'd8;
    tick();
    bus.start     = 1'b0;
    bus.frame_len = 8'd0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'sd3;
    repeat (5) tick();
    check("pre_rst_s_ready", bus.s_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_fir_xn", fir_xn, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    for (int i = 0; i < 4; i++) w_model[i] = 0;
    check_coefs();
    bus.s_valid = 1'b0;
    bus.s_data  = 8'sd0;
    tick();
    check("rst_held_done", bus.done, 0);
    rst = 1'b0;
    tick();

    // Normal frame after reload.
    for (int i = 0; i < 4; i++) write_coef(i, 1);
    smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 4;
    run_frame(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
